// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle instruction fetch controller.
//
// Issues a one-cycle read strobe to the instruction memory, waits WAIT_CYCLES
// access cycles, and captures the returned word. It then offers the word to the
// decoder over a valid/ready handshake. Branch redirects abandon the current
// fetch. Fetching stops after the word at i_end_addr has been handed over.
//
// Optional feature macro: FETCH_PERF_CNT_EN adds o_fetch_count, a saturating
// 16-bit count of completed decoder handshakes.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_start             begin fetching at address 0 (honoured in IDLE/DONE)
//   i_end_addr          last address to fetch, checked at each handshake
//   o_imem_addr         memory word address (current pc)
//   o_imem_rd           read strobe, high in the ISSUE cycle
//   i_imem_data         memory read data
//   o_instr             latched instruction
//   o_instr_valid       o_instr holds an unconsumed instruction
//   i_instr_ready       decoder accepts o_instr
//   i_redirect          branch/jump taken
//   i_redirect_addr     new fetch address
//   o_busy              high in ISSUE, WAIT and HOLD
//   o_done              high in DONE
//   o_fetch_count       (FETCH_PERF_CNT_EN only) completed handshakes
module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_imem_rd,
  input  logic [DATA_W-1:0] i_imem_data,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic              o_busy,
  output logic              o_done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       o_fetch_count
`endif
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StDone} state_e;

  // cnt counts down the remaining access cycles; zero means capture this edge.
  localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]       r_fetch_count;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_pc          <= '0;
      r_cnt         <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      r_fetch_count <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_pc    <= '0;
            r_state <= StIssue;
`ifdef FETCH_PERF_CNT_EN
            r_fetch_count <= '0;
`endif
          end
        end
        StIssue: begin
          if (i_redirect) begin
            // Re-issue at the new address; the strobe repeats next cycle.
            r_pc    <= i_redirect_addr;
            r_state <= StIssue;
          end else begin
            r_cnt   <= CntLoad;
            r_state <= StWait;
          end
        end
        StWait: begin
          if (i_redirect) begin
            r_pc    <= i_redirect_addr;
            r_state <= StIssue;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_instr       <= i_imem_data;
            r_instr_valid <= 1'b1;
            r_state       <= StHold;
          end
        end
        StHold: begin
`ifdef FETCH_PERF_CNT_EN
          if (i_instr_ready && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
          end
`endif
          if (i_redirect) begin
            // Handshake (if any) is complete; the end-address check is skipped.
            r_instr_valid <= 1'b0;
            r_pc          <= i_redirect_addr;
            r_state       <= StIssue;
          end else if (i_instr_ready) begin
            r_instr_valid <= 1'b0;
            if (r_pc == i_end_addr) begin
              r_state <= StDone;
            end else begin
              r_pc    <= r_pc + ADDR_W'(1);
              r_state <= StIssue;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_imem_addr   = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_imem_rd     = (r_state == StIssue);
  assign o_busy        = (r_state == StIssue) || (r_state == StWait) || (r_state == StHold);
  assign o_done        = (r_state == StDone);
`ifdef FETCH_PERF_CNT_EN
  assign o_fetch_count = r_fetch_count;
`endif

endmodule
